demux_striping: RTL and testbench

- Transmit-side counterpart of the lane un-striper. Splits one 32-bit word stream arriving at the fast clock (clk_2f) alternately into lane 0 and lane 1.
- Even-numbered accepted words go to lane 0; odd-numbered accepted words go to lane 1.
- Completed pairs are presented on both lanes simultaneously and held for two clk_2f cycles, so a clk_f-rate consumer samples each pair exactly once.
- Sits between the serial word source and the two-lane physical path.

---
 rtl/demux_striping_pkg.sv | 16 +
 rtl/demux_striping_if.sv | 32 +++
 rtl/demux_striping_hold_timer.sv | 41 ++++
 rtl/demux_striping.sv | 115 +++++++++++
 tb/tb_demux_striping.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/demux_striping_pkg.sv
// demux_striping_pkg
//   Shared types and defaults for the two-lane word striper.
//   - state_e      : pairing FSM encoding (ST_EMPTY = 0, ST_HALF = 1)
//   - DEF_*        : default parameter values used by the interface and modules
package demux_striping_pkg;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_HOLD_CYCLES  = 2;
    localparam int DEF_FLUSH_CYCLES = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } state_e;

endpackage

// File: rtl/demux_striping_if.sv
// demux_striping_if
//   Word-stream bus between the serial source and the two-lane striper.
//   master : word source / lane consumer side (drives data_in, valid_in)
//   slave  : striper side (drives both lanes and pair_pending)
//   Signals:
//     data_in, valid_in        serial input word, no backpressure
//     data_out0, valid_out0    lane 0 (even accepted words)
//     data_out1, valid_out1    lane 1 (odd accepted words)
//     pair_pending             a lane-0 word is buffered awaiting its partner
interface demux_striping_if
    import demux_striping_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] data_out0;
    logic                  valid_out0;
    logic [DATA_WIDTH-1:0] data_out1;
    logic                  valid_out1;
    logic                  pair_pending;

    modport master (
        output data_in, valid_in,
        input  data_out0, valid_out0, data_out1, valid_out1, pair_pending
    );

    modport slave (
        input  data_in, valid_in,
        output data_out0, valid_out0, data_out1, valid_out1, pair_pending
    );
endinterface

// File: rtl/demux_striping_hold_timer.sv
// stripe_hold_timer
//   Loadable down-counter that keeps the lane valids high for HOLD_CYCLES
//   clk_2f cycles after each load, so a clk_f consumer sees every pair once.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     load       reload the timer and lane valids this cycle
//     load_mask  which lanes become valid on this load (bit0 = lane 0)
//     lane_vld   registered per-lane valid
module stripe_hold_timer
    import demux_striping_pkg::*;
#(
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int NUM_LANES   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [NUM_LANES-1:0] load_mask,
    output logic [NUM_LANES-1:0] lane_vld
);
    localparam int TW = $clog2(HOLD_CYCLES + 1);

    logic [TW-1:0] timer_q;

    // lane_vld drops on the edge where the timer leaves 1, giving exactly
    // HOLD_CYCLES valid cycles per load while keeping the valids registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q  <= '0;
            lane_vld <= '0;
        end else if (load) begin
            timer_q  <= TW'(HOLD_CYCLES);
            lane_vld <= load_mask;
        end else begin
            if (timer_q != '0)
                timer_q <= timer_q - 1'b1;
            if (timer_q <= TW'(1))
                lane_vld <= '0;
        end
    end
endmodule

// File: rtl/demux_striping.sv
// demux_striping
//   Splits one clk_2f word stream into two lanes: even accepted words to
//   lane 0, odd accepted words to lane 1. A completed pair is loaded onto
//   both lanes together and held valid for HOLD_CYCLES cycles.
//   Optional macro STRIPE_FLUSH_EN: a lone lane-0 word left in HALF for
//   FLUSH_CYCLES consecutive idle cycles is pushed out on lane 0 alone.
//   Ports:
//     clk_2f  fast clock
//     reset   asynchronous active-high reset
//     bus     demux_striping_if.slave (data_in/valid_in in, both lanes and
//             pair_pending out; all outputs registered)
module demux_striping
    import demux_striping_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES
`ifdef STRIPE_FLUSH_EN
  , parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
`endif
) (
    input  logic             clk_2f,
    input  logic             reset,
    demux_striping_if.slave  bus
);
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic [DATA_WIDTH-1:0] out0_q, out0_d;
    logic [DATA_WIDTH-1:0] out1_q, out1_d;
    logic                  load;
    logic [1:0]            load_mask;
    logic [1:0]            lane_vld;

`ifdef STRIPE_FLUSH_EN
    localparam int IW = $clog2(FLUSH_CYCLES + 1);
    logic [IW-1:0] idle_q, idle_d;
`endif

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        out0_d    = out0_q;
        out1_d    = out1_q;
        load      = 1'b0;
        load_mask = 2'b00;
`ifdef STRIPE_FLUSH_EN
        idle_d    = '0;
`endif
        case (state_q)
            ST_EMPTY: begin
                if (bus.valid_in) begin
                    buf_d   = bus.data_in;
                    state_d = ST_HALF;
                end
            end
            ST_HALF: begin
                if (bus.valid_in) begin
                    out0_d    = buf_q;
                    out1_d    = bus.data_in;
                    load      = 1'b1;
                    load_mask = 2'b11;
                    state_d   = ST_EMPTY;
                end
`ifdef STRIPE_FLUSH_EN
                // this idle cycle is the FLUSH_CYCLES-th in a row
                else if (idle_q == IW'(FLUSH_CYCLES - 1)) begin
                    out0_d    = buf_q;
                    load      = 1'b1;
                    load_mask = 2'b01;
                    state_d   = ST_EMPTY;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
`endif
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            buf_q   <= '0;
            out0_q  <= '0;
            out1_q  <= '0;
`ifdef STRIPE_FLUSH_EN
            idle_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
`ifdef STRIPE_FLUSH_EN
            idle_q  <= idle_d;
`endif
        end
    end

    stripe_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .NUM_LANES   (2)
    ) u_hold_timer (
        .clk       (clk_2f),
        .rst       (reset),
        .load      (load),
        .load_mask (load_mask),
        .lane_vld  (lane_vld)
    );

    assign bus.data_out0    = out0_q;
    assign bus.data_out1    = out1_q;
    assign bus.valid_out0   = lane_vld[0];
    assign bus.valid_out1   = lane_vld[1];
    assign bus.pair_pending = (state_q == ST_HALF);
endmodule

// File: tb/tb_demux_striping.sv
// tb_demux_striping
//   Directed bench for demux_striping. Inputs change on the falling edge,
//   outputs are checked on the following falling edge. Control outputs are
//   compared as {pair_pending, valid_out0, valid_out1}.
module tb_demux_striping;
    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    demux_striping_if #(.DATA_WIDTH(32)) bus ();

    demux_striping dut (
        .clk_2f (clk),
        .reset  (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one input cycle from a falling edge; return on the next falling edge.
    task automatic step(input logic v, input logic [31:0] d);
        bus.valid_in = v;
        bus.data_in  = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        n_cmp++;
        if ({bus.pair_pending, bus.valid_out0, bus.valid_out1} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_ctl got %b exp 000", {bus.pair_pending, bus.valid_out0, bus.valid_out1});
        end
        n_cmp++;
        if ({bus.data_out0, bus.data_out1} !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_data got %h/%h exp 0/0", bus.data_out0, bus.data_out1);
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic        vin [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] din [6] = '{32'hAAAA0000, 32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003, 32'h0, 32'h0};
        logic [2:0]  ctl [6] = '{3'b100, 3'b011, 3'b111, 3'b011, 3'b011, 3'b000};
        logic [31:0] d0e [6] = '{32'h0, 32'hAAAA0000, 32'hAAAA0000, 32'hAAAA0002, 32'hAAAA0002, 32'hAAAA0002};
        logic [31:0] d1e [6] = '{32'h0, 32'hAAAA0001, 32'hAAAA0001, 32'hAAAA0003, 32'hAAAA0003, 32'hAAAA0003};
        for (int i = 0; i < 6; i++) begin
            step(vin[i], din[i]);
            n_cmp++;
            if ({bus.pair_pending, bus.valid_out0, bus.valid_out1} !== ctl[i]) begin
                n_bad++;
                $display("FAIL b2b_ctl[%0d] got %b exp %b", i, {bus.pair_pending, bus.valid_out0, bus.valid_out1}, ctl[i]);
            end
            n_cmp++;
            if ({bus.data_out0, bus.data_out1} !== {d0e[i], d1e[i]}) begin
                n_bad++;
                $display("FAIL b2b_data[%0d] got %h/%h exp %h/%h", i, bus.data_out0, bus.data_out1, d0e[i], d1e[i]);
            end
        end
    endtask

    task automatic test_gap;
        logic        vin [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] din [7] = '{32'h11, 32'h0, 32'h0, 32'h0, 32'h22, 32'h0, 32'h0};
        logic [2:0]  ctl [7] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b011, 3'b011, 3'b000};
        logic [31:0] d0e [7] = '{32'hAAAA0002, 32'hAAAA0002, 32'hAAAA0002, 32'hAAAA0002, 32'h11, 32'h11, 32'h11};
        logic [31:0] d1e [7] = '{32'hAAAA0003, 32'hAAAA0003, 32'hAAAA0003, 32'hAAAA0003, 32'h22, 32'h22, 32'h22};
        for (int i = 0; i < 7; i++) begin
            step(vin[i], din[i]);
            n_cmp++;
            if ({bus.pair_pending, bus.valid_out0, bus.valid_out1} !== ctl[i]) begin
                n_bad++;
                $display("FAIL gap_ctl[%0d] got %b exp %b", i, {bus.pair_pending, bus.valid_out0, bus.valid_out1}, ctl[i]);
            end
            n_cmp++;
            if ({bus.data_out0, bus.data_out1} !== {d0e[i], d1e[i]}) begin
                n_bad++;
                $display("FAIL gap_data[%0d] got %h/%h exp %h/%h", i, bus.data_out0, bus.data_out1, d0e[i], d1e[i]);
            end
        end
    endtask

    task automatic test_reset_pending;
        logic        vin [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] din [4] = '{32'h44, 32'h55, 32'h0, 32'h0};
        logic [2:0]  ctl [4] = '{3'b100, 3'b011, 3'b011, 3'b000};
        logic [31:0] d0e [4] = '{32'h0, 32'h44, 32'h44, 32'h44};
        logic [31:0] d1e [4] = '{32'h0, 32'h55, 32'h55, 32'h55};
        step(1'b1, 32'h33);
        n_cmp++;
        if (bus.pair_pending !== 1'b1) begin
            n_bad++;
            $display("FAIL rstp_pending got %b exp 1", bus.pair_pending);
        end
        // assert reset away from any clock edge; outputs must clear at once
        #2 rst = 1'b1;
        bus.valid_in = 1'b0;
        #1;
        n_cmp++;
        if ({bus.pair_pending, bus.valid_out0, bus.valid_out1} !== 3'b000) begin
            n_bad++;
            $display("FAIL rstp_async_ctl got %b exp 000", {bus.pair_pending, bus.valid_out0, bus.valid_out1});
        end
        n_cmp++;
        if ({bus.data_out0, bus.data_out1} !== 64'h0) begin
            n_bad++;
            $display("FAIL rstp_async_data got %h/%h exp 0/0", bus.data_out0, bus.data_out1);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(vin[i], din[i]);
            n_cmp++;
            if ({bus.pair_pending, bus.valid_out0, bus.valid_out1} !== ctl[i]) begin
                n_bad++;
                $display("FAIL rstp_ctl[%0d] got %b exp %b", i, {bus.pair_pending, bus.valid_out0, bus.valid_out1}, ctl[i]);
            end
            n_cmp++;
            if ({bus.data_out0, bus.data_out1} !== {d0e[i], d1e[i]}) begin
                n_bad++;
                $display("FAIL rstp_data[%0d] got %h/%h exp %h/%h", i, bus.data_out0, bus.data_out1, d0e[i], d1e[i]);
            end
        end
    endtask

`ifdef STRIPE_FLUSH_EN
    task automatic test_flush;
        logic        vin [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] din [9] = '{32'h66, 32'h0, 32'h0, 32'h0, 32'h0, 32'h77, 32'h88, 32'h0, 32'h0};
        logic [2:0]  ctl [9] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b010, 3'b110, 3'b011, 3'b011, 3'b000};
        logic [31:0] d0e [9] = '{32'h44, 32'h44, 32'h44, 32'h44, 32'h66, 32'h66, 32'h77, 32'h77, 32'h77};
        logic [31:0] d1e [9] = '{32'h55, 32'h55, 32'h55, 32'h55, 32'h55, 32'h55, 32'h88, 32'h88, 32'h88};
        for (int i = 0; i < 9; i++) begin
`else
    task automatic test_flush;
        logic        vin [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] din [8] = '{32'h66, 32'h0, 32'h0, 32'h0, 32'h0, 32'h77, 32'h0, 32'h0};
        logic [2:0]  ctl [8] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b011, 3'b011, 3'b000};
        logic [31:0] d0e [8] = '{32'h44, 32'h44, 32'h44, 32'h44, 32'h44, 32'h66, 32'h66, 32'h66};
        logic [31:0] d1e [8] = '{32'h55, 32'h55, 32'h55, 32'h55, 32'h55, 32'h77, 32'h77, 32'h77};
        for (int i = 0; i < 8; i++) begin
`endif
            step(vin[i], din[i]);
            n_cmp++;
            if ({bus.pair_pending, bus.valid_out0, bus.valid_out1} !== ctl[i]) begin
                n_bad++;
                $display("FAIL flush_ctl[%0d] got %b exp %b", i, {bus.pair_pending, bus.valid_out0, bus.valid_out1}, ctl[i]);
            end
            n_cmp++;
            if ({bus.data_out0, bus.data_out1} !== {d0e[i], d1e[i]}) begin
                n_bad++;
                $display("FAIL flush_data[%0d] got %h/%h exp %h/%h", i, bus.data_out0, bus.data_out1, d0e[i], d1e[i]);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in  = 32'h0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_gap();
        test_reset_pending();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
